// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, datapath
// select codes, ALU operations and condition codes.
package ctrl_pkg;

    localparam int unsigned ALUC_W = 3;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned COND_W = 4;
    localparam int unsigned FLAG_W = 4;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWRITE = 4'd4,
        S_MEMWB    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    // Instruction classes in Instr[27:26]
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_NOP = 2'b11;

    // ALU operations
    localparam logic [ALUC_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALUC_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALUC_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALUC_W-1:0] ALU_ORR = 3'b011;
    localparam logic [ALUC_W-1:0] ALU_EOR = 3'b100;
    localparam logic [ALUC_W-1:0] ALU_MUL = 3'b101;

    // Data-processing command field Funct[4:1]
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // Datapath select codes
    localparam logic [SEL_W-1:0] SRCA_REG      = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_PC       = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_WD       = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM      = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR     = 2'b10;
    localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
    localparam logic [SEL_W-1:0] RES_DATA      = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;

    // Condition codes in Instr[31:28]
    localparam logic [COND_W-1:0] COND_EQ = 4'b0000;
    localparam logic [COND_W-1:0] COND_NE = 4'b0001;
    localparam logic [COND_W-1:0] COND_CS = 4'b0010;
    localparam logic [COND_W-1:0] COND_CC = 4'b0011;
    localparam logic [COND_W-1:0] COND_MI = 4'b0100;
    localparam logic [COND_W-1:0] COND_PL = 4'b0101;
    localparam logic [COND_W-1:0] COND_VS = 4'b0110;
    localparam logic [COND_W-1:0] COND_VC = 4'b0111;
    localparam logic [COND_W-1:0] COND_HI = 4'b1000;
    localparam logic [COND_W-1:0] COND_LS = 4'b1001;
    localparam logic [COND_W-1:0] COND_GE = 4'b1010;
    localparam logic [COND_W-1:0] COND_LT = 4'b1011;
    localparam logic [COND_W-1:0] COND_GT = 4'b1100;
    localparam logic [COND_W-1:0] COND_LE = 4'b1101;
    localparam logic [COND_W-1:0] COND_AL = 4'b1110;

endpackage

// File: rtl/cond_unit.sv
// NZCV flags register, condition evaluation, latched CondExR and the
// condition-gated register/memory/PC write enables.
module cond_unit
    import ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [COND_W-1:0] cond,
    input  logic [FLAG_W-1:0] alu_flags,
    input  logic [1:0]        flag_w,
    input  logic              cond_latch,
    input  logic              flag_upd,
    input  logic              reg_w,
    input  logic              mem_w,
    input  logic              branch,
    input  logic              pc_fetch,
    input  logic              dst_pc,
    output logic              reg_write,
    output logic              mem_write,
    output logic              pc_write
);

    logic [FLAG_W-1:0] nzcv;
    logic              cond_ex_r;
    logic              cond_pass;
    logic              n, z, c, v;

    assign {n, z, c, v} = nzcv;

    // Evaluate the instruction condition against the current flags
    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            COND_EQ: cond_pass = z;
            COND_NE: cond_pass = ~z;
            COND_CS: cond_pass = c;
            COND_CC: cond_pass = ~c;
            COND_MI: cond_pass = n;
            COND_PL: cond_pass = ~n;
            COND_VS: cond_pass = v;
            COND_VC: cond_pass = ~v;
            COND_HI: cond_pass = c & ~z;
            COND_LS: cond_pass = ~c | z;
            COND_GE: cond_pass = (n == v);
            COND_LT: cond_pass = (n != v);
            COND_GT: cond_pass = ~z & (n == v);
            COND_LE: cond_pass = z | (n != v);
            COND_AL: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // Flags and condition latch; CondExR is captured before any flag update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nzcv      <= '0;
            cond_ex_r <= 1'b0;
        end else begin
            if (cond_latch) begin
                cond_ex_r <= cond_pass;
            end
            if (flag_upd && cond_ex_r) begin
                if (flag_w[1]) nzcv[3:2] <= alu_flags[3:2];
                if (flag_w[0]) nzcv[1:0] <= alu_flags[1:0];
            end
        end
    end

    // Condition-gated enables
    always_comb begin
        reg_write = reg_w & cond_ex_r;
        mem_write = mem_w & cond_ex_r;
        pc_write  = pc_fetch | (cond_ex_r & (branch | (reg_w & dst_pc)));
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle control unit: instruction decode, Moore sequencing FSM and
// flag/condition handling for the ARM-subset datapath.
// Optional build macro CTRL_MUL_EN: decodes the MUL encoding as a multiply.
module mc_controller
    import ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       Instr,
    input  logic [FLAG_W-1:0] ALUFlags,
    output logic              PCWrite,
    output logic              MemWrite,
    output logic              RegWrite,
    output logic              IRWrite,
    output logic              FPUWrite,
    output logic              AdrSrc,
    output logic [1:0]        RegSrc,
    output logic [SEL_W-1:0]  ALUSrcA,
    output logic [SEL_W-1:0]  ALUSrcB,
    output logic [SEL_W-1:0]  ResultSrc,
    output logic [1:0]        ImmSrc,
    output logic [ALUC_W-1:0] ALUControl
);

    state_t state, next_state;

    logic [1:0]        op;
    logic [5:0]        funct;
    logic [3:0]        rd;
    logic [3:0]        cmd;
    logic [ALUC_W-1:0] dp_alu;
    logic              no_write;
    logic              dp_known;
    logic [1:0]        flag_w;
    logic              dst_pc;
    logic              is_mul;
    logic              unused_bits;

    logic reg_w, mem_w, branch, pc_fetch, cond_latch, flag_upd;

    assign op          = Instr[27:26];
    assign funct       = Instr[25:20];
    assign rd          = Instr[15:12];
    assign cmd         = funct[4:1];
    assign unused_bits = ^{Instr[11:0], Instr[19:16]};

    // Operand-routing decode straight from the instruction
    assign ImmSrc   = op;
    assign RegSrc   = {(op == OP_MEM) & ~funct[0], (op == OP_BR)};
    assign FPUWrite = 1'b0;

`ifdef CTRL_MUL_EN
    assign is_mul = (op == OP_DP) & ~funct[5] & (cmd == CMD_AND) & (Instr[7:4] == 4'b1001);
    assign dst_pc = is_mul ? (Instr[19:16] == 4'hF) : (rd == 4'hF);
`else
    assign is_mul = 1'b0;
    assign dst_pc = (rd == 4'hF);
`endif

    // Data-processing op, write suppression and flag write enables
    always_comb begin
        dp_alu   = ALU_ADD;
        no_write = 1'b0;
        dp_known = 1'b1;
        case (cmd)
            CMD_ADD: dp_alu = ALU_ADD;
            CMD_SUB: dp_alu = ALU_SUB;
            CMD_AND: dp_alu = ALU_AND;
            CMD_ORR: dp_alu = ALU_ORR;
            CMD_EOR: dp_alu = ALU_EOR;
            CMD_CMP: begin
                dp_alu   = ALU_SUB;
                no_write = 1'b1;
            end
            default: begin
                dp_alu   = ALU_ADD;
                no_write = 1'b1;
                dp_known = 1'b0;
            end
        endcase
        if (is_mul) begin
            dp_alu = ALU_MUL;
        end
        flag_w[1] = funct[0] & dp_known;
        flag_w[0] = funct[0] & dp_known & ~is_mul
                  & ((cmd == CMD_ADD) | (cmd == CMD_SUB) | (cmd == CMD_CMP));
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:  next_state = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_MEM:  next_state = S_MEMADR;
                    OP_DP:   next_state = funct[5] ? S_EXECUTEI : S_EXECUTER;
                    OP_BR:   next_state = S_BRANCH;
                    default: next_state = S_FETCH;
                endcase
            end
            S_MEMADR:   next_state = funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  next_state = S_MEMWB;
            S_EXECUTER: next_state = S_ALUWB;
            S_EXECUTEI: next_state = S_ALUWB;
            default:    next_state = S_FETCH;
        endcase
    end

    // Moore outputs decoded from the state
    always_comb begin
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = SRCA_REG;
        ALUSrcB    = SRCB_WD;
        ResultSrc  = RES_ALUOUT;
        ALUControl = ALU_ADD;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        branch     = 1'b0;
        pc_fetch   = 1'b0;
        cond_latch = 1'b0;
        flag_upd   = 1'b0;
        case (state)
            S_FETCH: begin
                IRWrite   = 1'b1;
                pc_fetch  = 1'b1;
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            S_DECODE: begin
                ALUSrcA    = SRCA_PC;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALURESULT;
                cond_latch = 1'b1;
            end
            S_MEMADR:   ALUSrcB = SRCB_IMM;
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWRITE: begin
                AdrSrc = 1'b1;
                mem_w  = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                reg_w     = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcB    = SRCB_WD;
                ALUControl = dp_alu;
                flag_upd   = 1'b1;
            end
            S_EXECUTEI: begin
                ALUSrcB    = SRCB_IMM;
                ALUControl = dp_alu;
                flag_upd   = 1'b1;
            end
            S_ALUWB:    reg_w = ~no_write;
            S_BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
                branch    = 1'b1;
            end
            default: ;
        endcase
    end

    cond_unit u_cond (
        .clk        (clk),
        .reset      (reset),
        .cond       (Instr[31:28]),
        .alu_flags  (ALUFlags),
        .flag_w     (flag_w),
        .cond_latch (cond_latch),
        .flag_upd   (flag_upd),
        .reg_w      (reg_w),
        .mem_w      (mem_w),
        .branch     (branch),
        .pc_fetch   (pc_fetch),
        .dst_pc     (dst_pc),
        .reg_write  (RegWrite),
        .mem_write  (MemWrite),
        .pc_write   (PCWrite)
    );

endmodule
